// File: rtl/operand_stream_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_stream_tx_if : host push, job control and chip operand handshakes
// Rev 1.0
// ---------------------------------------------------------------------------
interface operand_stream_tx_if #(
   parameter int IO_DATA_WIDTH = 16,
   parameter int CNT_WIDTH     = 32
);
   logic                     host_a_push;
   logic [IO_DATA_WIDTH-1:0] host_a_data;
   logic                     host_a_full;
   logic                     host_b_push;
   logic [IO_DATA_WIDTH-1:0] host_b_data;
   logic                     host_b_full;
   logic [CNT_WIDTH-1:0]     cfg_a_words;
   logic [CNT_WIDTH-1:0]     cfg_b_words;
   logic                     go;
   logic                     busy;
   logic                     done;
   logic                     overflow;
   logic                     chip_start;
   logic                     chip_running;
   logic [IO_DATA_WIDTH-1:0] a_input;
   logic                     a_valid;
   logic                     a_ready;
   logic [IO_DATA_WIDTH-1:0] b_input;
   logic                     b_valid;
   logic                     b_ready;

   modport slave (
      input  host_a_push, host_a_data, host_b_push, host_b_data,
      input  cfg_a_words, cfg_b_words, go, chip_running, a_ready, b_ready,
      output host_a_full, host_b_full, busy, done, overflow, chip_start,
      output a_input, a_valid, b_input, b_valid
   );

   modport master (
      output host_a_push, host_a_data, host_b_push, host_b_data,
      output cfg_a_words, cfg_b_words, go, chip_running, a_ready, b_ready,
      input  host_a_full, host_b_full, busy, done, overflow, chip_start,
      input  a_input, a_valid, b_input, b_valid
   );
endinterface
`default_nettype wire

// File: rtl/operand_stream_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_stream_tx : buffers host A/B operand words and streams a counted job
// Rev 1.0
// ---------------------------------------------------------------------------
module operand_stream_tx #(
   parameter int IO_DATA_WIDTH = 16,
   parameter int FIFO_DEPTH    = 8,
   parameter int CNT_WIDTH     = 32
) (
   input  wire logic           clk,
   input  wire logic           arst_in,
   operand_stream_tx_if.slave  bus
);
   localparam int c_AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] c_IDLE     = 3'd0;
   localparam logic [2:0] c_START    = 3'd1;
   localparam logic [2:0] c_WAIT_RUN = 3'd2;
   localparam logic [2:0] c_STREAM   = 3'd3;
   localparam logic [2:0] c_DRAIN    = 3'd4;
   localparam logic [2:0] c_DONE     = 3'd5;

   localparam logic [c_AW-1:0]      c_PTR_ONE   = c_AW'(1);
   localparam logic [c_AW:0]        c_CNT_ONE   = (c_AW+1)'(1);
   localparam logic [c_AW:0]        c_CNT_DEPTH = (c_AW+1)'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] c_REM_ONE   = CNT_WIDTH'(1);

   logic [2:0] r_state;
   logic [2:0] w_state_nxt;
   logic       r_overflow;
   logic       w_load;

   logic [1:0]               w_push_req;
   logic [1:0]               w_ready;
   logic [1:0]               w_valid;
   logic [1:0]               w_full;
   logic [1:0]               w_ovf_set;
   logic [1:0]               w_rem_zero_nxt;
   logic [IO_DATA_WIDTH-1:0] w_wdata [2];
   logic [IO_DATA_WIDTH-1:0] w_head  [2];
   logic [CNT_WIDTH-1:0]     w_cfg   [2];

   assign w_load     = (r_state == c_IDLE) & bus.go;
   assign w_push_req = {bus.host_b_push, bus.host_a_push};
   assign w_ready    = {bus.b_ready, bus.a_ready};
   assign w_wdata[0] = bus.host_a_data;
   assign w_wdata[1] = bus.host_b_data;
   assign w_cfg[0]   = bus.cfg_a_words;
   assign w_cfg[1]   = bus.cfg_b_words;

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic [IO_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
      logic [c_AW-1:0]          r_wr_ptr;
      logic [c_AW-1:0]          r_rd_ptr;
      logic [c_AW:0]            r_count;
      logic                     r_full;
      logic [CNT_WIDTH-1:0]     r_rem;
      logic                     w_pop;
      logic                     w_push;
      logic [c_AW:0]            w_count_nxt;
      logic [CNT_WIDTH-1:0]     w_rem_nxt;

      // A full FIFO still accepts a push when the head pops in the same cycle
      assign w_pop        = w_valid[ch] & w_ready[ch];
      assign w_push       = w_push_req[ch] & (~r_full | w_pop);
      assign w_ovf_set[ch] = w_push_req[ch] & r_full & ~w_pop;
      assign w_valid[ch]  = (r_state == c_STREAM) & (r_count != '0) & (r_rem != '0);
      assign w_full[ch]   = r_full;
      assign w_head[ch]   = r_mem[r_rd_ptr];

      always_comb begin
         w_count_nxt = r_count;
         if (w_push & ~w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
         end else if (~w_push & w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
         end
      end

      always_comb begin
         w_rem_nxt = r_rem;
         if (w_load) begin
            w_rem_nxt = w_cfg[ch];
         end else if (w_pop) begin
            w_rem_nxt = r_rem - c_REM_ONE;
         end
      end

      assign w_rem_zero_nxt[ch] = (w_rem_nxt == '0);

      always_ff @(posedge clk or posedge arst_in) begin
         if (arst_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_rem    <= '0;
         end else begin
            if (w_push) begin
               r_mem[r_wr_ptr] <= w_wdata[ch];
               r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNT_DEPTH);
            r_rem   <= w_rem_nxt;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:     if (bus.go) w_state_nxt = c_START;
         c_START:    w_state_nxt = c_WAIT_RUN;
         c_WAIT_RUN: if (bus.chip_running) w_state_nxt = c_STREAM;
         c_STREAM:   if (&w_rem_zero_nxt) w_state_nxt = c_DRAIN;
         c_DRAIN:    if (!bus.chip_running) w_state_nxt = c_DONE;
         c_DONE:     w_state_nxt = c_IDLE;
         default:    w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         r_state    <= c_IDLE;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_overflow <= r_overflow | (|w_ovf_set);
      end
   end

   assign bus.busy        = (r_state != c_IDLE);
   assign bus.done        = (r_state == c_DONE);
   assign bus.chip_start  = (r_state == c_START);
   assign bus.overflow    = r_overflow;
   assign bus.host_a_full = w_full[0];
   assign bus.host_b_full = w_full[1];
   assign bus.a_input     = w_head[0];
   assign bus.a_valid     = w_valid[0];
   assign bus.b_input     = w_head[1];
   assign bus.b_valid     = w_valid[1];
endmodule
`default_nettype wire

// File: tb/tb_operand_stream_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_operand_stream_tx : directed self-checking bench for operand_stream_tx
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_operand_stream_tx;
   logic clk;
   logic arst_in;

   operand_stream_tx_if #(.IO_DATA_WIDTH(16), .CNT_WIDTH(32)) bus();

   operand_stream_tx #(.IO_DATA_WIDTH(16), .FIFO_DEPTH(8), .CNT_WIDTH(32)) u_dut (
      .clk     (clk),
      .arst_in (arst_in),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_done   = 0;
   int n_start  = 0;
   int n_valid  = 0;
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   int          qa_cyc[$];
   logic        a_stall = 1'b0;
   logic        b_stall = 1'b0;
   logic [15:0] a_hold  = '0;
   logic [15:0] b_hold  = '0;
   logic        rnd_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Transfer log plus hold-while-stalled checks, sampled mid-cycle
   always @(negedge clk) begin
      if (arst_in) begin
         a_stall = 1'b0;
         b_stall = 1'b0;
      end else begin
         if (a_stall) begin
            check("a_hold_valid", bus.a_valid, 1);
            check("a_hold_data", bus.a_input, a_hold);
         end
         if (b_stall) begin
            check("b_hold_valid", bus.b_valid, 1);
            check("b_hold_data", bus.b_input, b_hold);
         end
         if (bus.a_valid && bus.a_ready) begin
            qa.push_back(bus.a_input);
            qa_cyc.push_back(cyc);
         end
         if (bus.b_valid && bus.b_ready) qb.push_back(bus.b_input);
         a_stall = bus.a_valid && !bus.a_ready;
         b_stall = bus.b_valid && !bus.b_ready;
         a_hold  = bus.a_input;
         b_hold  = bus.b_input;
         if (bus.done)                   n_done++;
         if (bus.chip_start)             n_start++;
         if (bus.a_valid || bus.b_valid) n_valid++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ready();
      bus.a_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.b_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic push_ab(input logic pa, input logic [15:0] da, input logic pb, input logic [15:0] db);
      bus.host_a_push = pa;
      bus.host_a_data = da;
      bus.host_b_push = pb;
      bus.host_b_data = db;
      tick();
      bus.host_a_push = 1'b0;
      bus.host_b_push = 1'b0;
   endtask

   task automatic run_job(input int ca, input int cb);
      int d0;
      d0 = n_done;
      qa.delete();
      qb.delete();
      qa_cyc.delete();
      bus.cfg_a_words = ca;
      bus.cfg_b_words = cb;
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      check("start_pulse", bus.chip_start, 1);
      bus.chip_running = 1'b1;
      repeat (3) begin
         set_ready();
         tick();
      end
      for (int i = 0; i < 300 && !(qa.size() >= ca && qb.size() >= cb); i++) begin
         set_ready();
         tick();
      end
      check("xfer_complete", 32'(qa.size() >= ca && qb.size() >= cb), 1);
      bus.chip_running = 1'b0;
      for (int i = 0; i < 20 && n_done == d0; i++) tick();
      tick();
      check("done_once", n_done - d0, 1);
      check("idle_after", bus.busy, 0);
   endtask

   initial begin
      int s0;
      int v0;
      int d0;
      arst_in = 1'b1;
      bus.host_a_push = 1'b0; bus.host_a_data = '0;
      bus.host_b_push = 1'b0; bus.host_b_data = '0;
      bus.cfg_a_words = '0;   bus.cfg_b_words = '0;
      bus.go = 1'b0; bus.chip_running = 1'b0;
      bus.a_ready = 1'b0; bus.b_ready = 1'b0;
      repeat (2) tick();

      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_ovf", bus.overflow, 0);
      check("rst_start", bus.chip_start, 0);
      check("rst_avalid", bus.a_valid, 0);
      check("rst_afull", bus.host_a_full, 0);
      check("rst_ainput", bus.a_input, 0);
      arst_in = 1'b0;
      tick();

      // Basic 4/4 job, ready tied high
      for (int i = 0; i < 4; i++) push_ab(1'b1, 16'(i + 1), 1'b1, 16'(i + 5));
      s0 = n_start;
      run_job(4, 4);
      check("basic_start_cnt", n_start - s0, 1);
      check("basic_a_cnt", qa.size(), 4);
      check("basic_b_cnt", qb.size(), 4);
      for (int i = 0; i < 4 && i < qa.size(); i++) check("basic_a_word", qa[i], i + 1);
      for (int i = 0; i < 4 && i < qb.size(); i++) check("basic_b_word", qb[i], i + 5);
      if (qa_cyc.size() == 4) check("basic_consecutive", qa_cyc[3] - qa_cyc[0], 3);

      // Random backpressure
      for (int i = 0; i < 6; i++) push_ab(1'b1, 16'(16'h10 + i), 1'b1, 16'(16'h20 + i));
      rnd_ready = 1'b1;
      run_job(6, 6);
      rnd_ready = 1'b0;
      check("bp_a_cnt", qa.size(), 6);
      check("bp_b_cnt", qb.size(), 6);
      for (int i = 0; i < 6 && i < qa.size(); i++) check("bp_a_word", qa[i], 16'h10 + i);
      for (int i = 0; i < 6 && i < qb.size(); i++) check("bp_b_word", qb[i], 16'h20 + i);

      // Count limit: 5 pushed, 2 sent, remaining 3 lead the next job
      for (int i = 0; i < 5; i++) push_ab(1'b1, 16'(16'h31 + i), 1'b0, '0);
      run_job(2, 0);
      check("lim_a_cnt", qa.size(), 2);
      for (int i = 0; i < 2 && i < qa.size(); i++) check("lim_a_word", qa[i], 16'h31 + i);
      check("lim_b_cnt", qb.size(), 0);
      check("lim_left_head", bus.a_input, 16'h33);
      run_job(3, 0);
      check("lim2_a_cnt", qa.size(), 3);
      for (int i = 0; i < 3 && i < qa.size(); i++) check("lim2_a_word", qa[i], 16'h33 + i);

      // Fill and overflow
      for (int i = 0; i < 7; i++) push_ab(1'b1, 16'(16'h40 + i), 1'b0, '0);
      check("full_after7", bus.host_a_full, 0);
      push_ab(1'b1, 16'h47, 1'b0, '0);
      check("full_after8", bus.host_a_full, 1);
      check("ovf_before9", bus.overflow, 0);
      push_ab(1'b1, 16'h48, 1'b0, '0);
      check("ovf_after9", bus.overflow, 1);
      check("full_after9", bus.host_a_full, 1);
      run_job(8, 0);
      check("ovf_a_cnt", qa.size(), 8);
      for (int i = 0; i < 8 && i < qa.size(); i++) check("ovf_a_word", qa[i], 16'h40 + i);
      check("ovf_sticky", bus.overflow, 1);
      check("ovf_empty_after", bus.host_a_full, 0);

      // Zero-count job with a word waiting
      push_ab(1'b1, 16'h77, 1'b0, '0);
      s0 = n_start;
      v0 = n_valid;
      d0 = n_done;
      run_job(0, 0);
      check("zero_start", n_start - s0, 1);
      check("zero_no_valid", n_valid - v0, 0);
      check("zero_done", n_done - d0, 1);

      // Reset mid-STREAM with words queued
      for (int i = 0; i < 3; i++) push_ab(1'b1, 16'(16'h80 + i), 1'b1, 16'(16'h90 + i));
      bus.a_ready = 1'b0;
      bus.b_ready = 1'b0;
      bus.cfg_a_words = 3;
      bus.cfg_b_words = 3;
      bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
      bus.chip_running = 1'b1;
      repeat (3) tick();
      check("mid_avalid", bus.a_valid, 1);
      check("mid_ahead", bus.a_input, 16'h77);
      arst_in = 1'b1;
      #1;
      check("arst_avalid", bus.a_valid, 0);
      check("arst_bvalid", bus.b_valid, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_afull", bus.host_a_full, 0);
      check("arst_ainput", bus.a_input, 0);
      tick();
      arst_in = 1'b0;
      bus.chip_running = 1'b0;
      tick();
      push_ab(1'b1, 16'h99, 1'b1, 16'hAA);
      run_job(1, 1);
      check("post_rst_a_cnt", qa.size(), 1);
      if (qa.size() == 1) check("post_rst_a_word", qa[0], 16'h99);
      if (qb.size() == 1) check("post_rst_b_word", qb[0], 16'hAA);
      check("post_rst_avalid", bus.a_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
